serial_sub: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Its per-bit datapath is our half/full-subtract cell (difference = XOR, borrow = ~x & y) plus a registered borrow.
- Sits between operand registers and the result consumer, using a start/busy/done handshake.
- Trades area for latency: WIDTH+1 cycles from start to done.

---
 rtl/serial_sub.sv | 128 ++++++++++++
 tb/tb_serial_sub.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, start/busy/done handshake.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic             br_r;
  logic [CW-1:0]    cnt_r;
`ifdef SERIAL_SUB_OVF_EN
  logic [1:0]       msb_r;   // {a MSB, b MSB} of the captured operands
`endif

  logic d_s;
  logic bnext_s;
  logic last_s;

  // Full-subtract cell: difference bit
  function automatic logic sub_diff(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // Full-subtract cell: borrow out
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // Per-bit datapath on the current LSBs of the shift registers
  always_comb begin
    d_s     = sub_diff(sa_r[0], sb_r[0], br_r);
    bnext_s = sub_borrow(sa_r[0], sb_r[0], br_r);
    last_s  = (cnt_r == CNT_LAST);
  end

  // Control FSM, operand shifters, and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      sa_r       <= {WIDTH{1'b0}};
      sb_r       <= {WIDTH{1'b0}};
      br_r       <= 1'b0;
      cnt_r      <= CNT_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= {WIDTH{1'b0}};
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      msb_r      <= 2'b00;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            sa_r    <= a;
            sb_r    <= b;
            br_r    <= 1'b0;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b1;
            state_r <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            msb_r   <= {a[WIDTH-1], b[WIDTH-1]};
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // Result bits enter at the MSB so the first (LSB) bit lands at bit 0
          diff  <= {d_s, diff[WIDTH-1:1]};
          sa_r  <= {1'b0, sa_r[WIDTH-1:1]};
          sb_r  <= {1'b0, sb_r[WIDTH-1:1]};
          br_r  <= bnext_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (last_s) begin
            borrow_out <= bnext_s;
            busy       <= 1'b0;
            done       <= 1'b1;
            state_r    <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
            // d_s is the final MSB of diff on this edge
            ovf        <= (msb_r[1] != msb_r[0]) && (d_s != msb_r[1]);
`endif
          end else begin
            state_r <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (WIDTH=8) with hand-computed results.
module tb_serial_sub;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int n_cmp;
  int n_err;

  serial_sub #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation, optionally disturb a/b after capture, wait for done and check
  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic [7:0] exp_d, input logic exp_bo, input bit disturb);
    int cyc;
    int busy_cnt;
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (disturb) begin
      a = 8'hAA;
      b = 8'h55;
    end
    cyc = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      if (busy) busy_cnt++;
    end
    check_eq({tag, ".latency"}, cyc, WIDTH);
    check_eq({tag, ".busy_cycles"}, busy_cnt, WIDTH);
    check_eq({tag, ".done"}, done, 1'b1);
    check_eq({tag, ".diff"}, diff, exp_d);
    check_eq({tag, ".borrow"}, borrow_out, exp_bo);
    tick();
    check_eq({tag, ".done_drop"}, done, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    tick();
    check_eq("rst.busy", busy, 1'b0);
    check_eq("rst.done", done, 1'b0);
    check_eq("rst.diff", diff, 8'h00);
    check_eq("rst.borrow", borrow_out, 1'b0);
    rst = 1'b0;
    tick();

    run_op("basic", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op("under", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("equal", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Results hold in IDLE while start is low
    a = 8'h12;
    b = 8'h34;
    tick();
    tick();
    tick();
    check_eq("hold.diff", diff, 8'h00);
    check_eq("hold.busy", busy, 1'b0);

    run_op("capture", 8'h40, 8'h04, 8'h3C, 1'b0, 1'b1);

    // Back-to-back: start held high; starts during busy/DONE ignored
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    tick();                                   // edge 0
    for (int i = 1; i <= WIDTH; i++) tick();  // edges 1..8
    check_eq("b2b.done1", done, 1'b1);
    check_eq("b2b.diff1", diff, 8'h0F);
    tick();                                   // edge 9
    check_eq("b2b.edge9_busy", busy, 1'b0);
    check_eq("b2b.edge9_done", done, 1'b0);
    tick();                                   // edge 10
    check_eq("b2b.edge10_busy", busy, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= WIDTH; i++) tick();
    check_eq("b2b.done2", done, 1'b1);
    check_eq("b2b.diff2", diff, 8'h0F);
    tick();

    // Reset mid-operation aborts immediately and silently
    a = 8'h5A;
    b = 8'h23;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("abort.pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_eq("abort.busy", busy, 1'b0);
    check_eq("abort.done", done, 1'b0);
    check_eq("abort.diff", diff, 8'h00);
    check_eq("abort.borrow", borrow_out, 1'b0);
    tick();
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (done) seen++;
      end
      check_eq("abort.no_done", seen, 0);
    end
    run_op("after_rst", 8'h33, 8'h44, 8'hEF, 1'b1, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf_pos", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0);
    check_eq("ovf_pos.ovf", ovf, 1'b1);
    run_op("ovf_neg", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    check_eq("ovf_neg.ovf", ovf, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
